// File: rtl/pll_seq_ctrl_if.sv
// Register-side configuration channel for the PLL sequencer.
// The requester holds cfg_req_i until it sees the one-cycle cfg_ack_o.
interface pll_seq_ctrl_if;
  logic        cfg_req_i;
  logic [9:0]  cfg_ratio_i;
  logic [23:0] cfg_fraction_i;
  logic [9:0]  cfg_zdiv0_ratio_i;
  logic        cfg_ack_o;

  modport master (
    output cfg_req_i, cfg_ratio_i, cfg_fraction_i, cfg_zdiv0_ratio_i,
    input  cfg_ack_o
  );

  modport slave (
    input  cfg_req_i, cfg_ratio_i, cfg_fraction_i, cfg_zdiv0_ratio_i,
    output cfg_ack_o
  );
endinterface

// File: rtl/pll_seq_ctrl.sv
// PLL power-up / lock / reconfiguration sequencer: LDO ramp, lock qualification,
// lock timeout and loss-of-lock handling, and req/ack latching of the PLL map fields.
module pll_seq_ctrl #(
  parameter int unsigned LDO_WAIT_CYC     = 64,
  parameter int unsigned LOCK_FILT        = 4,
  parameter int unsigned LOCK_TIMEOUT_CYC = 4096,
  parameter int unsigned PLLEN_OFF_CYC    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          powergood_vnn_i,
  pll_seq_ctrl_if.slave cfg,
  input  logic          pll_lock_i,
  output logic          ldo_enable_o,
  output logic          pllen_o,
  output logic          bypass_o,
  output logic [9:0]    ratio_o,
  output logic [23:0]   fraction_o,
  output logic [9:0]    zdiv0_ratio_o,
  output logic          locked_o,
  output logic          busy_o,
  output logic          err_timeout_o,
  output logic          lock_lost_o,
  output logic [2:0]    state_o
);

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_LDO_UP    = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_RELOCK    = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  localparam int unsigned MAX_A   = (LDO_WAIT_CYC > PLLEN_OFF_CYC) ? LDO_WAIT_CYC : PLLEN_OFF_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > LOCK_TIMEOUT_CYC) ? MAX_A : LOCK_TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned FILT_W  = $clog2(LOCK_FILT + 1);

  localparam logic [CNT_W-1:0]  LDO_LAST  = CNT_W'(LDO_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(PLLEN_OFF_CYC - 1);
  localparam logic [FILT_W-1:0] FILT_SAT  = FILT_W'(LOCK_FILT);

  logic              sync1;
  logic              lock_s;
  logic [FILT_W-1:0] filt_cnt;
  logic              qlock;
  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              run;
  logic              tmo_set;
  logic              lost_set;
  logic              sticky_clr;
  logic              cfg_take;

  assign run     = enable_i & powergood_vnn_i;
  assign qlock   = (filt_cnt >= FILT_SAT);
  assign state_o = state;

  // Lock qualification: two-flop synchronizer, then a saturating run-length filter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1    <= 1'b0;
      lock_s   <= 1'b0;
      filt_cnt <= '0;
    end else begin
      sync1  <= pll_lock_i;
      lock_s <= sync1;
      if (!lock_s)
        filt_cnt <= '0;
      else if (!qlock)
        filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    tmo_set  = 1'b0;
    lost_set = 1'b0;
    case (state)
      ST_OFF:       if (run) state_nx = ST_LDO_UP;
      ST_LDO_UP:    if (cnt == LDO_LAST) state_nx = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (qlock) begin
          state_nx = ST_LOCKED;
        end else if (cnt == TMO_LAST) begin
          state_nx = ST_ERROR;
          tmo_set  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          lost_set = 1'b1;
        end else if (cfg.cfg_req_i) begin
          state_nx = ST_RELOCK;
        end
      end
      ST_RELOCK:    if (cnt == OFF_LAST) state_nx = ST_WAIT_LOCK;
      ST_ERROR:     state_nx = ST_ERROR;
      default:      state_nx = ST_OFF;
    endcase
    // Power-down wins over everything, including flag-setting transitions.
    if (!run && state != ST_OFF) begin
      state_nx = ST_OFF;
      tmo_set  = 1'b0;
      lost_set = 1'b0;
    end
  end

  assign sticky_clr = (state == ST_OFF) && (state_nx == ST_LDO_UP);
  assign cfg_take   = cfg.cfg_req_i && !cfg.cfg_ack_o &&
                      ((state == ST_OFF) || (state == ST_ERROR) ||
                       ((state == ST_LOCKED) && (state_nx == ST_RELOCK)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_OFF;
      cnt           <= '0;
      ldo_enable_o  <= 1'b0;
      pllen_o       <= 1'b0;
      bypass_o      <= 1'b1;
      locked_o      <= 1'b0;
      busy_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      lock_lost_o   <= 1'b0;
      cfg.cfg_ack_o <= 1'b0;
      ratio_o       <= '0;
      fraction_o    <= '0;
      zdiv0_ratio_o <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= (state_nx != state) ? '0 : cnt + 1'b1;
      ldo_enable_o <= (state_nx != ST_OFF);
      pllen_o      <= (state_nx == ST_WAIT_LOCK) || (state_nx == ST_LOCKED);
      bypass_o     <= (state_nx != ST_LOCKED);
      locked_o     <= (state_nx == ST_LOCKED);
      busy_o       <= (state_nx == ST_LDO_UP) || (state_nx == ST_WAIT_LOCK) ||
                      (state_nx == ST_RELOCK);
      if (sticky_clr) begin
        err_timeout_o <= 1'b0;
        lock_lost_o   <= 1'b0;
      end else begin
        if (tmo_set)  err_timeout_o <= 1'b1;
        if (lost_set) lock_lost_o   <= 1'b1;
      end
      cfg.cfg_ack_o <= cfg_take;
      if (cfg_take) begin
        ratio_o       <= cfg.cfg_ratio_i;
        fraction_o    <= cfg.cfg_fraction_i;
        zdiv0_ratio_o <= cfg.cfg_zdiv0_ratio_i;
      end
    end
  end

endmodule

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
- Power-up, lock and reconfiguration sequencer for the on-die PLL.
- Drives the LDO enable, PLL enable, bypass and ratio/fraction/zdiv0 fields of the PLL map.
- Qualifies the PLL lock indication and handles lock timeout and loss of lock.
- Accepts new frequency configurations from a register-side requester through a req/ack handshake.

Parameters:
- LDO_WAIT_CYC, 64: cycles spent in LDO_UP before the PLL is enabled (≥1).
- LOCK_FILT, 4: consecutive synchronized lock-high samples required to declare lock (≥1).
- LOCK_TIMEOUT_CYC, 4096: cycles allowed in WAIT_LOCK before an error is raised (> LOCK_FILT+2).
- PLLEN_OFF_CYC, 8: cycles pllen is held low during a relock (≥1).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; 1 = run PLL, 0 = power down.
- powergood_vnn_i  in  1  supply good; 0 is treated as enable_i=0.
- cfg_req_i  in  1  new configuration request; held until ack.
- cfg_ratio_i  in  10  requested feedback ratio.
- cfg_fraction_i  in  24  requested fractional part.
- cfg_zdiv0_ratio_i  in  10  requested post-divider ratio.
- cfg_ack_o  out  1  one-cycle pulse when the configuration is latched.
- pll_lock_i  in  1  raw, asynchronous PLL lock.
- ldo_enable_o  out  1  LDO enable.
- pllen_o  out  1  PLL enable.
- bypass_o  out  1  1 = downstream clock uses the reference clock.
- ratio_o  out  10  applied ratio.
- fraction_o  out  24  applied fraction.
- zdiv0_ratio_o  out  10  applied zdiv0 ratio.
- locked_o  out  1  qualified lock, state LOCKED only.
- busy_o  out  1  state is LDO_UP, WAIT_LOCK or RELOCK.
- err_timeout_o  out  1  sticky; lock timeout occurred.
- lock_lost_o  out  1  sticky; lock dropped while LOCKED.
- state_o  out  3  encoded state for debug.

Behaviour:
- Reset values:
  - State = OFF.
  - ldo_enable_o=0, pllen_o=0, bypass_o=1, locked_o=0, busy_o=0, cfg_ack_o=0, err_timeout_o=0, lock_lost_o=0.
  - ratio_o=10'd0, fraction_o=0, zdiv0_ratio_o=10'd0.
  - Sync flops and counters = 0.
- Lock synchronization: pll_lock_i passes through a 2-flop synchronizer, giving lock_s. A filter counter increments while lock_s=1 and clears when lock_s=0. qlock = (filter counter ≥ LOCK_FILT).
- State encoding: OFF=0, LDO_UP=1, WAIT_LOCK=2, LOCKED=3, RELOCK=4, ERROR=5.
- run = enable_i & powergood_vnn_i.
- The cycle counter clears on every state entry. "N cycles" means the state exits at the edge where counter==N-1.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- OFF:
  - ldo=0, pllen=0, bypass=1.
  - run=1 -> LDO_UP.
- LDO_UP:
  - ldo=1, pllen=0, bypass=1.
  - After LDO_WAIT_CYC cycles -> WAIT_LOCK.
- WAIT_LOCK:
  - ldo=1, pllen=1, bypass=1.
  - qlock -> LOCKED.
  - Counter reaches LOCK_TIMEOUT_CYC-1 without qlock -> ERROR and set err_timeout_o.
  - If qlock and timeout occur on the same edge, qlock wins.
- LOCKED:
  - ldo=1, pllen=1, bypass=0, locked_o=1.
  - lock_s=0 -> WAIT_LOCK, set lock_lost_o; this takes priority over cfg_req_i.
  - cfg_req_i=1 -> RELOCK.
- RELOCK:
  - ldo=1, pllen=0, bypass=1.
  - After PLLEN_OFF_CYC cycles -> WAIT_LOCK.
- ERROR:
  - ldo=1, pllen=0, bypass=1.
  - Exit only through run=0 -> OFF.
- From any state except OFF, run=0 -> OFF on the next edge. This overrides every other transition.
- Config handshake:
  - Config is latched in OFF, ERROR, or on the LOCKED->RELOCK edge, whenever cfg_req_i=1 and cfg_ack_o was 0 in the previous cycle.
  - Latching updates ratio_o/fraction_o/zdiv0_ratio_o and pulses cfg_ack_o for exactly 1 cycle.
  - In LDO_UP, WAIT_LOCK and RELOCK the request is held off (no ack) until a latching state is reached.
  - In LOCKED, a request with lock loss on the same edge is not acked; it is acked later, in OFF, ERROR or a later LOCKED->RELOCK edge.
  - ratio_o never changes while pllen_o=1.
- Sticky flags clear only on rst_i or on the OFF->LDO_UP transition.
- Asserting rst_i mid-sequence returns all outputs to reset values asynchronously.

Test Plan:
- Power-up: enable_i=1, lock rises 100 cycles after pllen_o -> pllen_o rises 64 cycles after ldo_enable_o; locked_o=1 and bypass_o=0 at pllen_o rise + 100 + 2 sync + 4 filter cycles.
- Timeout: pll_lock_i tied 0 -> err_timeout_o=1, state=5, pllen_o=0 exactly 4096 cycles after pllen_o rose; then enable_i=0 -> state=0; enable_i=1 clears the flag.
- Reconfig: LOCKED, cfg_req_i with ratio=10'd80, fraction=24'h400000 -> 1-cycle cfg_ack_o, bypass_o=1, pllen_o low 8 cycles, ratio_o=80 before pllen_o rises, relock reaches LOCKED.
- Lock loss: in LOCKED, drop pll_lock_i for 3 cycles -> bypass_o=1, lock_lost_o=1, state=2, LOCKED re-entered after filter; sticky flag persists.
- Abort: enable_i=0 during WAIT_LOCK and again during RELOCK -> next edge ldo_enable_o=0, pllen_o=0, bypass_o=1, state=0; rst_i pulse mid-LDO_UP gives the same result asynchronously.
- Held request: cfg_req_i asserted during LDO_UP -> no ack until OFF/ERROR or the LOCKED->RELOCK edge; exactly one ack per request.
